// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port (AR + R) between the instruction and data caches.
// Round-robin grant held from the AR handshake through the RLAST beat; one burst outstanding.
module axi_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_arvalid,
  input  logic [ADDR_WIDTH-1:0] ic_araddr,
  input  logic [7:0]            ic_arlen,
  input  logic [2:0]            ic_arsize,
  input  logic [1:0]            ic_arburst,
  output logic                  ic_arready,
  output logic                  ic_rvalid,
  input  logic                  ic_rready,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_rlast,
  input  logic                  dc_arvalid,
  input  logic [ADDR_WIDTH-1:0] dc_araddr,
  input  logic [7:0]            dc_arlen,
  input  logic [2:0]            dc_arsize,
  input  logic [1:0]            dc_arburst,
  output logic                  dc_arready,
  output logic                  dc_rvalid,
  input  logic                  dc_rready,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_rlast,
  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  grant_dc,
  output logic                  busy,
  output logic                  burst_error
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic       last_grant_dc;
  logic [7:0] beat_cnt;

  logic       own_arvalid;
  logic [7:0] own_arlen;
  logic       own_rready;
  logic       beat;

  assign own_arvalid = grant_dc ? dc_arvalid : ic_arvalid;
  assign own_arlen   = grant_dc ? dc_arlen   : ic_arlen;
  assign own_rready  = grant_dc ? dc_rready  : ic_rready;
  assign beat        = m_axi_rvalid && m_axi_rready;

  // Arbitration, burst tracking and beat-count checking
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      grant_dc      <= 1'b0;
      last_grant_dc <= 1'b1;
      beat_cnt      <= 8'd0;
      burst_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_arvalid || dc_arvalid) begin
            grant_dc <= (ic_arvalid && dc_arvalid) ? !last_grant_dc : dc_arvalid;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (!own_arvalid) begin
            state <= IDLE;
          end else if (m_axi_arready) begin
            beat_cnt <= own_arlen;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (m_axi_rlast) begin
              state         <= IDLE;
              last_grant_dc <= grant_dc;
              if (beat_cnt != 8'd0) burst_error <= 1'b1;
            end else if (beat_cnt == 8'd0) begin
              burst_error <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake steering toward the current owner
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'd0;
    m_axi_arburst = 2'd0;
    m_axi_rready  = 1'b0;
    ic_arready    = 1'b0;
    dc_arready    = 1'b0;
    ic_rvalid     = 1'b0;
    dc_rvalid     = 1'b0;
    case (state)
      ADDR: begin
        m_axi_arvalid = own_arvalid;
        m_axi_araddr  = grant_dc ? dc_araddr  : ic_araddr;
        m_axi_arlen   = own_arlen;
        m_axi_arsize  = grant_dc ? dc_arsize  : ic_arsize;
        m_axi_arburst = grant_dc ? dc_arburst : ic_arburst;
        ic_arready    = !grant_dc && m_axi_arready;
        dc_arready    = grant_dc && m_axi_arready;
      end
      DATA: begin
        m_axi_rready = own_rready;
        ic_rvalid    = !grant_dc && m_axi_rvalid;
        dc_rvalid    = grant_dc && m_axi_rvalid;
      end
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign ic_rdata = m_axi_rdata;
  assign dc_rdata = m_axi_rdata;
  assign ic_rlast = m_axi_rlast;
  assign dc_rlast = m_axi_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: memory side driven by hand, expectations fixed per burst.
module tb_axi_read_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ic_arvalid, dc_arvalid;
  logic [63:0] ic_araddr, dc_araddr;
  logic [7:0]  ic_arlen, dc_arlen;
  logic [2:0]  ic_arsize, dc_arsize;
  logic [1:0]  ic_arburst, dc_arburst;
  logic        ic_arready, dc_arready;
  logic        ic_rvalid, dc_rvalid;
  logic        ic_rready, dc_rready;
  logic [63:0] ic_rdata, dc_rdata;
  logic        ic_rlast, dc_rlast;
  logic        m_axi_arvalid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic        grant_dc, busy, burst_error;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_err = 1'b0;

  always #5 clock = ~clock;

  axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
    .ic_arsize(ic_arsize), .ic_arburst(ic_arburst), .ic_arready(ic_arready),
    .ic_rvalid(ic_rvalid), .ic_rready(ic_rready), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast),
    .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
    .dc_arsize(dc_arsize), .dc_arburst(dc_arburst), .dc_arready(dc_arready),
    .dc_rvalid(dc_rvalid), .dc_rready(dc_rready), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .grant_dc(grant_dc), .busy(busy), .burst_error(burst_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input bit dc, input logic [63:0] addr, input logic [7:0] len, input bit v);
    if (dc) begin
      dc_arvalid = v; dc_araddr = addr; dc_arlen = len; dc_arsize = 3'd3; dc_arburst = 2'd1;
    end else begin
      ic_arvalid = v; ic_araddr = addr; ic_arlen = len; ic_arsize = 3'd3; ic_arburst = 2'd1;
    end
  endtask

  // One full burst for the given owner; called and returns just after a negedge with the arbiter idle
  task automatic burst(input bit dc, input logic [63:0] addr, input logic [7:0] len,
                       input int nbeats, input int ar_wait, input bit toggle, input bit rereq);
    int          beats;
    int          cyc;
    logic        rr;
    logic [63:0] d;
    set_req(dc, addr, len, 1'b1);
    #1 check("idle_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(negedge clock); #1;
    check("grant_dc", 64'(grant_dc), 64'(dc));
    check("busy_addr", 64'(busy), 64'd1);
    check("m_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("m_araddr", m_axi_araddr, addr);
    check("m_arlen", 64'(m_axi_arlen), 64'(len));
    check("m_arsize", 64'(m_axi_arsize), 64'd3);
    for (int i = 0; i < ar_wait; i++) begin
      check("arready_held", 64'(dc ? dc_arready : ic_arready), 64'd0);
      @(negedge clock); #1;
      check("m_arvalid_held", 64'(m_axi_arvalid), 64'd1);
      check("m_araddr_stable", m_axi_araddr, addr);
    end
    m_axi_arready = 1'b1;
    #1;
    check("own_arready", 64'(dc ? dc_arready : ic_arready), 64'd1);
    check("other_arready", 64'(dc ? ic_arready : dc_arready), 64'd0);
    @(negedge clock);
    m_axi_arready = 1'b0;
    if (!rereq) begin
      if (dc) dc_arvalid = 1'b0; else ic_arvalid = 1'b0;
    end
    beats = 0;
    cyc   = 0;
    while (beats < nbeats && cyc < 64) begin
      rr = toggle ? (cyc % 2 == 1) : 1'b1;
      if (dc) begin dc_rready = rr; ic_rready = !rr; end
      else    begin ic_rready = rr; dc_rready = !rr; end
      d = {addr[31:0], 32'(beats)};
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rlast  = (beats == nbeats - 1);
      #1;
      check("own_rvalid", 64'(dc ? dc_rvalid : ic_rvalid), 64'd1);
      check("other_rvalid", 64'(dc ? ic_rvalid : dc_rvalid), 64'd0);
      check("m_rready", 64'(m_axi_rready), 64'(rr));
      check("rdata", dc ? dc_rdata : ic_rdata, d);
      check("no_arready_data", 64'({ic_arready, dc_arready}), 64'd0);
      if (rr) beats++;
      cyc++;
      @(negedge clock);
    end
    check("beat_count", 64'(beats), 64'(nbeats));
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    ic_rready    = 1'b0;
    dc_rready    = 1'b0;
    #1;
    check("busy_done", 64'(busy), 64'd0);
    check("burst_error", 64'(burst_error), 64'(exp_err));
  endtask

  initial begin
    reset = 1'b0;
    set_req(1'b0, 64'd0, 8'd0, 1'b0);
    set_req(1'b1, 64'd0, 8'd0, 1'b0);
    ic_rready = 1'b0; dc_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_dc), 64'd0);
    check("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_m_rready", 64'(m_axi_rready), 64'd0);
    check("rst_m_araddr", m_axi_araddr, 64'd0);
    check("rst_readies", 64'({ic_arready, dc_arready, ic_rvalid, dc_rvalid}), 64'd0);
    check("rst_err", 64'(burst_error), 64'd0);
    reset = 1'b1;
    @(negedge clock); #1;

    // Single icache burst, then AR backpressure and toggling dcache rready
    burst(1'b0, 64'h1000, 8'd7, 8, 0, 1'b0, 1'b0);
    burst(1'b0, 64'h2000, 8'd7, 8, 5, 1'b0, 1'b0);
    burst(1'b1, 64'h3000, 8'd7, 8, 0, 1'b1, 1'b0);

    // Simultaneous requests from reset: ic, dc, ic, dc
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1; #1;
    set_req(1'b1, 64'h4100, 8'd3, 1'b1);
    burst(1'b0, 64'h4000, 8'd3, 4, 0, 1'b0, 1'b1);
    burst(1'b1, 64'h4100, 8'd3, 4, 0, 1'b0, 1'b1);
    burst(1'b0, 64'h4000, 8'd3, 4, 0, 1'b0, 1'b0);
    burst(1'b1, 64'h4100, 8'd3, 4, 0, 1'b0, 1'b0);
    @(negedge clock); #1;
    check("no_third_arb", 64'(busy), 64'd0);

    // Owner withdraws before arready; round-robin state must be untouched (dcache was last)
    set_req(1'b0, 64'h5000, 8'd3, 1'b1);
    @(negedge clock); #1;
    check("wd_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("wd_grant", 64'(grant_dc), 64'd0);
    ic_arvalid = 1'b0;
    #1 check("wd_drop", 64'(m_axi_arvalid), 64'd0);
    @(negedge clock); #1;
    check("wd_idle", 64'(busy), 64'd0);
    check("wd_no_rvalid", 64'(ic_rvalid), 64'd0);
    set_req(1'b1, 64'h5100, 8'd1, 1'b1);
    burst(1'b0, 64'h5200, 8'd1, 2, 0, 1'b0, 1'b0);
    burst(1'b1, 64'h5100, 8'd1, 2, 0, 1'b0, 1'b0);

    // Early rlast on beat 4 of an 8-beat burst; error is sticky
    exp_err = 1'b1;
    burst(1'b0, 64'h6000, 8'd7, 4, 0, 1'b0, 1'b0);
    burst(1'b1, 64'h6100, 8'd1, 2, 0, 1'b0, 1'b0);

    // Reset asserted during beat 3 of a dcache burst
    set_req(1'b1, 64'h7000, 8'd7, 1'b1);
    @(negedge clock); m_axi_arready = 1'b1;
    @(negedge clock); m_axi_arready = 1'b0; dc_arvalid = 1'b0; dc_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'(i);
      m_axi_rlast  = 1'b0;
      if (i == 2) reset = 1'b0;
      #1 check("rst_mid_beat", 64'(dc_rvalid), 64'd1);
      @(negedge clock);
    end
    #1;
    check("rstm_rvalid", 64'(dc_rvalid), 64'd0);
    check("rstm_rready", 64'(m_axi_rready), 64'd0);
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_grant", 64'(grant_dc), 64'd0);
    check("rstm_err", 64'(burst_error), 64'd0);
    reset = 1'b1; m_axi_rvalid = 1'b0; dc_rready = 1'b0; exp_err = 1'b0;
    @(negedge clock); #1;
    burst(1'b1, 64'h8000, 8'd3, 4, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
